floo_vc_credit_selection: RTL

Per-output-port VC selection stage of the FlooNoC VC router. It tracks credits for every VC of the downstream input port and, for each preferred VC id, offers a VC that currently has a free buffer slot. Its outputs feed the VC assignment stage directly. After switch-allocation winners are known, that stage picks the offered VC; the picked VC is reported back here so its credit is consumed.

---
 rtl/floo_vc_credit_selection.sv | 111 +++++++++++
 1 files changed

// File: rtl/floo_vc_credit_selection.sv
// Per-output-port VC credit tracking and VC offer for the VC assignment stage.
// Define FLOO_VC_SEL_FALLBACK_EN to let an empty preferred VC fall back to the next VC with credit.
module floo_vc_credit_selection #(
    parameter int NumVC       = 4,
    parameter int NumVCWidth  = NumVC > 1 ? $clog2(NumVC) : 1,
    parameter int VCDepth     = 2,
    parameter int CreditWidth = $clog2(VCDepth + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumVC-1:0]              credit_v_i,
    input  logic                          vc_assignment_v_i,
    input  logic [NumVCWidth-1:0]         vc_assignment_id_i,
    output logic [NumVC-1:0]              vc_selection_v_o,
    output logic [NumVC*NumVCWidth-1:0]   vc_selection_id_o,
    output logic [NumVC*CreditWidth-1:0]  credit_cnt_o,
    output logic                          credit_err_o
);

    localparam logic [CreditWidth-1:0] FullCnt = CreditWidth'(VCDepth);
    localparam logic [CreditWidth-1:0] OneCnt  = CreditWidth'(1);

    logic [CreditWidth-1:0] cnt_reg  [NumVC];
    logic [CreditWidth-1:0] cnt_next [NumVC];
    logic [NumVC-1:0]       overflow;
    logic [NumVC-1:0]       underflow;
    logic [NumVC-1:0]       has_credit;
    logic                   err_reg;
    logic                   err_next;

    genvar gi;
    generate
        for (gi = 0; gi < NumVC; gi++) begin : g_cnt
            logic inc;
            logic dec;

            // Out-of-range ids never match any VC, so they are silently dropped.
            assign inc = credit_v_i[gi];
            assign dec = vc_assignment_v_i && (vc_assignment_id_i == NumVCWidth'(gi));

            always_comb begin
                cnt_next[gi]  = cnt_reg[gi];
                overflow[gi]  = 1'b0;
                underflow[gi] = 1'b0;
                if (inc && !dec) begin
                    if (cnt_reg[gi] == FullCnt) begin
                        overflow[gi] = 1'b1;
                    end else begin
                        cnt_next[gi] = cnt_reg[gi] + OneCnt;
                    end
                end else if (dec && !inc) begin
                    if (cnt_reg[gi] == '0) begin
                        underflow[gi] = 1'b1;
                    end else begin
                        cnt_next[gi] = cnt_reg[gi] - OneCnt;
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_reg[gi] <= FullCnt;
                end else begin
                    cnt_reg[gi] <= cnt_next[gi];
                end
            end

            assign has_credit[gi] = (cnt_reg[gi] != '0);
            assign credit_cnt_o[gi*CreditWidth +: CreditWidth] = cnt_reg[gi];
        end

        for (gi = 0; gi < NumVC; gi++) begin : g_sel
            logic                  sel_v;
            logic [NumVCWidth-1:0] sel_id;

`ifdef FLOO_VC_SEL_FALLBACK_EN
            // Round-robin-style scan starting just after the preferred VC.
            always_comb begin
                sel_v  = has_credit[gi];
                sel_id = NumVCWidth'(gi);
                for (int k = 1; k < NumVC; k++) begin
                    if (!sel_v && has_credit[(gi + k) % NumVC]) begin
                        sel_v  = 1'b1;
                        sel_id = NumVCWidth'((gi + k) % NumVC);
                    end
                end
            end
`else
            assign sel_v  = has_credit[gi];
            assign sel_id = NumVCWidth'(gi);
`endif

            assign vc_selection_v_o[gi]                             = sel_v;
            assign vc_selection_id_o[gi*NumVCWidth +: NumVCWidth] = sel_id;
        end
    endgenerate

    // Sticky until reset so that a single protocol violation is never missed.
    assign err_next = err_reg || (|overflow) || (|underflow);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign credit_err_o = err_reg;

endmodule
